// File: rtl/asmd_pkg.sv
// rtl/asmd_pkg.sv - shared ASMD arithmetic definitions (multiplier and divider)
package asmd_pkg;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_DIVIDE = 1'b1
  } asmd_state_t;

  localparam int WORD_LENGTH = 8;

endpackage

// File: rtl/asmd_divider_datapath.sv
// rtl/asmd_divider_datapath.sv - restoring-divider shift registers, subtractor and counter
module asmd_divider_datapath
  import asmd_pkg::*;
#(
  parameter int word_length = WORD_LENGTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic                   shift,
  input  logic [word_length-1:0] word0,
  input  logic [word_length-1:0] word1,
  output logic [word_length-1:0] quotient_next,
  output logic [word_length-1:0] remainder_next,
  output logic                   count_zero
);

  localparam int CW = $clog2(word_length + 1);

  logic [word_length-1:0] dividend;
  logic [word_length-1:0] divisor;
  logic [word_length:0]   partial_rem;
  logic [CW-1:0]          count;

  logic [word_length:0]   r_trial;
  logic [word_length:0]   r_diff;
  logic                   fits;
  logic [word_length:0]   rem_step;

  // Top bit of partial_rem is always zero (remainder < divisor), so it drops out of the shift.
  assign r_trial  = (word_length + 1)'({partial_rem, dividend[word_length-1]});
  assign r_diff   = r_trial - {1'b0, divisor};
  assign fits     = r_trial >= {1'b0, divisor};
  assign rem_step = fits ? r_diff : r_trial;

  // Dividend register doubles as the quotient: result bits enter at the LSB as dividend bits leave.
  assign quotient_next  = {dividend[word_length-2:0], fits};
  assign remainder_next = rem_step[word_length-1:0];

  // High on the shift that takes the counter from 1 to 0, i.e. the final iteration.
  assign count_zero = (count == CW'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dividend    <= '0;
      divisor     <= '0;
      partial_rem <= '0;
      count       <= '0;
    end else if (load) begin
      dividend    <= word0;
      divisor     <= word1;
      partial_rem <= '0;
      count       <= CW'(word_length);
    end else if (shift) begin
      dividend    <= quotient_next;
      partial_rem <= rem_step;
      count       <= count - CW'(1);
    end
  end

endmodule

// File: rtl/asmd_divider.sv
// rtl/asmd_divider.sv - sequential unsigned restoring divider with start/ready handshake
module asmd_divider
  import asmd_pkg::*;
#(
  parameter int word_length = WORD_LENGTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [word_length-1:0] word0,
  input  logic [word_length-1:0] word1,
  input  logic                   start,
  output logic [word_length-1:0] quotient,
  output logic [word_length-1:0] remainder,
  output logic                   ready,
  output logic                   div_by_zero
);

  asmd_state_t            state;
  logic                   load;
  logic                   shift;
  logic                   count_zero;
  logic [word_length-1:0] quotient_next;
  logic [word_length-1:0] remainder_next;

  assign load  = (state == S_IDLE) && start && (word1 != '0);
  assign shift = (state == S_DIVIDE);

  asmd_divider_datapath #(
    .word_length(word_length)
  ) u_datapath (
    .clk            (clk),
    .reset          (reset),
    .load           (load),
    .shift          (shift),
    .word0          (word0),
    .word1          (word1),
    .quotient_next  (quotient_next),
    .remainder_next (remainder_next),
    .count_zero     (count_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      quotient    <= '0;
      remainder   <= '0;
      ready       <= 1'b1;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (word1 == '0) begin
              // Zero divisor resolves in the accepting cycle without leaving idle.
              quotient    <= '1;
              remainder   <= word0;
              div_by_zero <= 1'b1;
            end else begin
              state <= S_DIVIDE;
              ready <= 1'b0;
            end
          end
        end
        S_DIVIDE: begin
          if (count_zero) begin
            quotient    <= quotient_next;
            remainder   <= remainder_next;
            div_by_zero <= 1'b0;
            ready       <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_asmd_divider.sv
// tb/tb_asmd_divider.sv - self-checking bench for asmd_divider
module tb_asmd_divider;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] word0 = '0;
  logic [7:0] word1 = '0;
  logic       start = 1'b0;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       ready;
  logic       div_by_zero;

  int checks = 0;
  int errors = 0;

  asmd_divider #(.word_length(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .word0       (word0),
    .word1       (word1),
    .start       (start),
    .quotient    (quotient),
    .remainder   (remainder),
    .ready       (ready),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
    int         busy;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Issues one start at the current time (caller is #1 after an edge) and
  // returns the number of cycles ready stayed low.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, output int busy);
    word0 = a;
    word1 = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    busy = 0;
    while (ready !== 1'b1 && busy < 50) begin
      busy++;
      @(posedge clk);
      #1;
    end
    if (busy >= 50) begin
      checks++;
      errors++;
      $display("FAIL timeout: ready never returned, a=%0d b=%0d", a, b);
    end
  endtask

  initial begin
    int busy;
    int lo;
    logic [7:0] a, b, eq, er;
    logic edbz;

    vecs[0] = '{8'd200, 8'd7,   8'd28,  8'd4,  1'b0, 8};
    vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0,  1'b0, 8};
    vecs[2] = '{8'd5,   8'd9,   8'd0,   8'd5,  1'b0, 8};
    vecs[3] = '{8'd255, 8'd255, 8'd1,   8'd0,  1'b0, 8};
    vecs[4] = '{8'd0,   8'd3,   8'd0,   8'd0,  1'b0, 8};
    vecs[5] = '{8'd42,  8'd0,   8'd255, 8'd42, 1'b1, 0};
    vecs[6] = '{8'd9,   8'd2,   8'd4,   8'd1,  1'b0, 8};

    #100;
    reset = 1'b0;
    @(negedge clk);
    check("reset_quotient", quotient, 0);
    check("reset_remainder", remainder, 0);
    check("reset_ready", ready, 1);
    check("reset_dbz", div_by_zero, 0);

    @(posedge clk);
    #1;
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, busy);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
      check($sformatf("vec%0d_quotient", i), quotient, vecs[i].q);
      check($sformatf("vec%0d_remainder", i), remainder, vecs[i].r);
      check($sformatf("vec%0d_dbz", i), div_by_zero, vecs[i].dbz);
    end

    // Start while busy must be ignored; outputs hold the previous result meanwhile.
    word0 = 8'd100;
    word1 = 8'd10;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    word0 = 8'd50;
    word1 = 8'd3;
    start = 1'b1;
    check("busy_hold_quotient", quotient, 4);
    check("busy_hold_remainder", remainder, 1);
    @(posedge clk);
    #1;
    start = 1'b0;
    lo = 0;
    while (ready !== 1'b1 && lo < 50) begin
      lo++;
      @(posedge clk);
      #1;
    end
    check("busy_start_quotient", quotient, 10);
    check("busy_start_remainder", remainder, 0);
    check("busy_start_ready", ready, 1);
    @(posedge clk);
    #1;
    check("busy_start_no_retrigger", ready, 1);

    // Asynchronous reset in the middle of an operation.
    word0 = 8'd200;
    word1 = 8'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midreset_quotient", quotient, 0);
    check("midreset_remainder", remainder, 0);
    check("midreset_ready", ready, 1);
    check("midreset_dbz", div_by_zero, 0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_idle", ready, 1);
    run_op(8'd200, 8'd7, busy);
    check("post_reset_quotient", quotient, 28);
    check("post_reset_remainder", remainder, 4);

    // Random back-to-back sweep against plain integer division.
    for (int n = 0; n < 1000; n++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 15) == 0) b = 8'd0;
      if (b == 0) begin
        eq = 8'hff;
        er = a;
        edbz = 1'b1;
      end else begin
        eq = a / b;
        er = a % b;
        edbz = 1'b0;
      end
      run_op(a, b, busy);
      check("rand_busy", busy, (b == 0) ? 0 : 8);
      check("rand_quotient", quotient, eq);
      check("rand_remainder", remainder, er);
      check("rand_dbz", div_by_zero, edbz);
      if (b != 0) begin
        check("rand_identity", longint'(quotient) * b + remainder, a);
        check("rand_rem_lt_div", remainder < b, 1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
